viterbi_traceback: RTL and testbench

//  Survivor-memory/traceback stage directly downstream of the 4-state ACS bank (K=3 code).

---
 rtl/viterbi_traceback_pkg.sv | 23 ++
 rtl/viterbi_traceback_if.sv | 25 ++
 rtl/viterbi_traceback_survivor_mem.sv | 27 ++
 rtl/viterbi_traceback.sv | 146 ++++++++++++++
 tb/tb_viterbi_traceback.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_traceback_pkg.sv
// Shared types for the K=3, 4-state Viterbi decoder: trellis state, decision column,
// traceback FSM encoding and the predecessor helper.
package viterbi_pkg;

    localparam int unsigned NST  = 4;
    localparam int unsigned ST_W = 2;

    typedef logic [ST_W-1:0] state_t;
    typedef logic [NST-1:0]  dec_col_t;

    typedef enum logic [1:0] {
        FILL,
        ACCEPT,
        TRAIN,
        DECODE
    } tb_fsm_t;

    // State s = {u_c, u_c-1}; its predecessor shifts in the stored survivor bit.
    function automatic state_t pred_state(state_t s, dec_col_t d);
        return {s[0], d[s]};
    endfunction

endpackage

// File: rtl/viterbi_traceback_if.sv
// Decision-column input and decoded-word output handshakes of the traceback stage.
interface viterbi_traceback_if #(
    parameter int unsigned L = 16
);
    import viterbi_pkg::*;

    logic           enable;
    logic           in_ready;
    dec_col_t       dec;
    state_t         best_state;
    logic           out_valid;
    logic           out_ready;
    logic [L-1:0]   out_word;

    modport master (
        output enable, dec, best_state, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  enable, dec, best_state, out_ready,
        output in_ready, out_valid, out_word
    );

endinterface

// File: rtl/viterbi_traceback_survivor_mem.sv
// Circular survivor memory: one decision column per trellis step, synchronous write,
// asynchronous read. Contents are intentionally not reset.
module tb_survivor_mem
    import viterbi_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  dec_col_t        wdata,
    input  logic [AW-1:0]   raddr,
    output dec_col_t        rdata
);

    dec_col_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// Block traceback after the ACS bank: stores decision columns, trains L steps back from
// the best state, then decodes the next-older L steps into one word (oldest bit in bit 0).
module viterbi_traceback
    import viterbi_pkg::*;
#(
    parameter int unsigned L = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    viterbi_traceback_if.slave      bus
);

    localparam int unsigned AW = $clog2(2 * L);
    localparam int unsigned KW = $clog2(L);

    tb_fsm_t        state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [KW-1:0]  step_q, step_d;
    state_t         best_q, best_d;
    state_t         tb_state_q, tb_state_d;
    logic [L-1:0]   shadow_q, shadow_d;
    logic [L-1:0]   out_word_q, out_word_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic           accept;
    logic           start_tb;
    dec_col_t       rd_col;

    assign accept = bus.enable & in_ready_q;

    tb_survivor_mem #(
        .DEPTH (2 * L),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (bus.dec),
        .raddr (rd_ptr_q),
        .rdata (rd_col)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        best_d      = best_q;
        tb_state_d  = tb_state_q;
        shadow_d    = shadow_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        start_tb    = 1'b0;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            cnt_d    = cnt_q + AW'(1);
            best_d   = bus.best_state;
        end

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                if (accept && cnt_q == AW'(2 * L - 1)) begin
                    start_tb = 1'b1;
                end
            end
            ACCEPT: begin
                if (cnt_q == AW'(L) && !out_valid_q) begin
                    start_tb = 1'b1;
                end
            end
            TRAIN: begin
                tb_state_d = pred_state(tb_state_q, rd_col);
                rd_ptr_d   = rd_ptr_q - AW'(1);
                step_d     = step_q + KW'(1);
                if (step_q == KW'(L - 1)) begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                shadow_d[KW'(L - 1) - step_q] = tb_state_q[1];
                tb_state_d = pred_state(tb_state_q, rd_col);
                rd_ptr_d   = rd_ptr_q - AW'(1);
                step_d     = step_q + KW'(1);
                if (step_q == KW'(L - 1)) begin
                    out_word_d  = shadow_d;
                    out_valid_d = 1'b1;
                    state_d     = ACCEPT;
                end
            end
            default: state_d = FILL;
        endcase

        // Traceback starts from the column just committed (this edge's write in FILL).
        if (start_tb) begin
            state_d    = TRAIN;
            cnt_d      = '0;
            step_d     = '0;
            tb_state_d = best_d;
            rd_ptr_d   = wr_ptr_d - AW'(1);
        end

        in_ready_d = (state_d == FILL) || (state_d == ACCEPT && cnt_d < AW'(L));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            step_q      <= '0;
            best_q      <= '0;
            tb_state_q  <= '0;
            shadow_q    <= '0;
            out_word_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            best_q      <= best_d;
            tb_state_q  <= tb_state_d;
            shadow_q    <= shadow_d;
            out_word_q  <= out_word_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: decision columns are generated from known message
// bits along the true encoder path, so each decoded word must equal the message slice.
`timescale 1ns/1ps
module tb_viterbi_traceback;
    import viterbi_pkg::*;

    localparam int unsigned L = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    viterbi_traceback_if #(.L(L)) vif ();

    viterbi_traceback #(.L(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        u1, u2;
    int unsigned edges, low, seen, got, cyc;
    logic [143:0] msg6;
    logic [15:0]  exp_w;
    state_t       bogus;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input dec_col_t d, input state_t bs);
        int unsigned w;
        w = 0;
        vif.enable     = 1'b1;
        vif.dec        = d;
        vif.best_state = bs;
        while (!vif.in_ready && w < 600) begin
            @(negedge clk);
            w++;
        end
        if (!vif.in_ready) check("push_in_ready_timeout", 32'(vif.in_ready), 32'd1);
        @(negedge clk);
        vif.enable = 1'b0;
    endtask

    // True path state {u_c, u_c-1}; its survivor bit is u_c-2, other states get noise.
    task automatic send_bit(input logic b);
        state_t   s;
        dec_col_t d;
        s    = {b, u1};
        d    = dec_col_t'($urandom);
        d[s] = u2;
        push(d, s);
        u2 = u1;
        u1 = b;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) send_bit(w[i]);
    endtask

    task automatic wait_valid(output int unsigned e);
        e = 0;
        while (!vif.out_valid && e < 200) begin
            @(negedge clk);
            e++;
        end
        if (!vif.out_valid) check("out_valid_timeout", 32'(vif.out_valid), 32'd1);
    endtask

    task automatic handshake(input string tag);
        vif.out_ready = 1'b1;
        @(negedge clk);
        vif.out_ready = 1'b0;
        check(tag, 32'(vif.out_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst           = 1'b0;
        vif.enable    = 1'b0;
        vif.out_ready = 1'b0;
        u1            = 1'b0;
        u2            = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b0;
        vif.enable     = 1'b0;
        vif.dec        = '0;
        vif.best_state = '0;
        vif.out_ready  = 1'b0;
        u1             = 1'b0;
        u2             = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(vif.in_ready), 32'd1);
        check("rst_out_valid", 32'(vif.out_valid), 32'd0);
        check("rst_out_word", 32'(vif.out_word), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // 1: all-zero decisions, latency and stall length
        for (int i = 0; i < 32; i++) push(4'h0, 2'd0);
        check("t1_in_ready_fall", 32'(vif.in_ready), 32'd0);
        edges = 0;
        low   = 0;
        while (!vif.out_valid && edges < 100) begin
            if (!vif.in_ready) low++;
            @(negedge clk);
            edges++;
        end
        check("t1_latency", edges, 32'd32);
        check("t1_in_ready_low", low, 32'd32);
        check("t1_word", 32'(vif.out_word), 32'h0000);
        check("t1_in_ready_accept", 32'(vif.in_ready), 32'd1);
        handshake("t1_out_valid_drop");

        // 2: known message decode
        do_reset();
        send_word(16'hA5C3);
        send_word(16'h3C96);
        wait_valid(edges);
        check("t2_word", 32'(vif.out_word), 32'hA5C3);

        // 3: consumer stalls; 16 columns collected then in_ready drops
        send_word(16'h5A0F);
        check("t3_in_ready_full", 32'(vif.in_ready), 32'd0);
        check("t3_valid_held", 32'(vif.out_valid), 32'd1);
        check("t3_word_held", 32'(vif.out_word), 32'hA5C3);
        bogus = ~{u1, u2};
        for (int i = 0; i < 6; i++) begin
            vif.enable     = 1'b1;
            vif.dec        = 4'hF;
            vif.best_state = bogus;
            @(negedge clk);
        end
        vif.enable = 1'b0;
        check("t3_word_stable", 32'(vif.out_word), 32'hA5C3);
        check("t3_in_ready_stall", 32'(vif.in_ready), 32'd0);
        handshake("t3_out_valid_drop");
        wait_valid(edges);
        check("t3_handshake_to_valid", edges, 32'd33);
        check("t3_word2", 32'(vif.out_word), 32'h3C96);
        handshake("t3_out_valid_drop2");

        // 4: enable asserted while stalled in traceback must be ignored
        send_word(16'hC3A5);
        check("t4_in_ready_low", 32'(vif.in_ready), 32'd0);
        edges = 0;
        while (!vif.out_valid && edges < 200) begin
            vif.enable     = 1'b1;
            vif.dec        = 4'hF;
            vif.best_state = 2'd3;
            @(negedge clk);
            edges++;
        end
        vif.enable = 1'b0;
        check("t4_latency", edges, 32'd33);
        check("t4_word", 32'(vif.out_word), 32'h5A0F);
        handshake("t4_out_valid_drop");
        send_word(16'h1234);
        wait_valid(edges);
        check("t4_next_word", 32'(vif.out_word), 32'hC3A5);
        handshake("t4_out_valid_drop2");

        // 5: reset pulse during DECODE
        send_word(16'hBEEF);
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_out_valid", 32'(vif.out_valid), 32'd0);
        check("t5_rst_in_ready", 32'(vif.in_ready), 32'd1);
        check("t5_rst_out_word", 32'(vif.out_word), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        u1  = 1'b0;
        u2  = 1'b0;
        @(negedge clk);
        send_word(16'h6D2B);
        exp_w = 16'h71E4;
        for (int i = 0; i < 15; i++) send_bit(exp_w[i]);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (vif.out_valid) seen++;
            @(negedge clk);
        end
        check("t5_no_early_word", seen, 32'd0);
        check("t5_still_filling", 32'(vif.in_ready), 32'd1);
        send_bit(exp_w[15]);
        wait_valid(edges);
        check("t5_latency", edges, 32'd32);
        check("t5_word", 32'(vif.out_word), 32'h6D2B);

        // 6: random stream, 8 words, random consumer back-pressure
        do_reset();
        for (int i = 0; i < 144; i++) msg6[i] = 1'($urandom);
        got = 0;
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 144; i++) send_bit(msg6[i]);
            end
            begin
                while (got < 8 && cyc < 6000) begin
                    @(negedge clk);
                    cyc++;
                    vif.out_ready = ($urandom_range(0, 2) != 0);
                    if (vif.out_valid && vif.out_ready) begin
                        for (int j = 0; j < 16; j++) exp_w[j] = msg6[16 * got + j];
                        check($sformatf("t6_word%0d", got), 32'(vif.out_word), 32'(exp_w));
                        got++;
                    end
                end
                vif.out_ready = 1'b0;
            end
        join
        check("t6_word_count", got, 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
